// File: rtl/mem_rmw_ctrl_if.sv
// CPU-side request/response bus of the read-modify-write memory controller.
// The master is the CPU and the slave is the controller.
interface mem_rmw_ctrl_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        Mem_Req_Ack;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ack;

  modport master (
    output Address, MemWrite, MemRead,
    output Write_data, Write_strb,
    output Read_data_Ack,
    input  Mem_Req_Ack, Read_data,
    input  Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, MemRead,
    input  Write_data, Write_strb,
    input  Read_data_Ack,
    output Mem_Req_Ack, Read_data,
    output Read_data_Valid
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Memory controller with configurable wait states and byte-strobe
// read-modify-write for partial stores to a word-wide ideal memory.
module mem_rmw_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_rmw_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-3:0] Waddr,
  output logic [ADDR_WIDTH-3:0] Raddr,
  output logic                  Wren,
  output logic                  Rden,
  output logic [31:0]           Wdata,
  input  logic [31:0]           Rdata
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [2:0] {
    IDLE, WAIT, RD, WR, RESP
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            strb_q;
  logic                  is_wr_q;
  logic [31:0]           old_q;
  logic [31:0]           rdata_q;
  logic                  accept;
  logic [31:0]           merged;

  // Address bits outside the word index are don't-care.
  logic unused_addr;
  assign unused_addr = ^{bus.Address[31:ADDR_WIDTH],
                         bus.Address[1:0]};

  // Where an operation goes once its wait states are done.
  function automatic state_t route(input logic wr,
                                   input logic [3:0] s);
    if (!wr)               return RD;
    else if (s == 4'b1111) return WR;
    else if (s == 4'b0000) return RESP;
    else                   return RD;
  endfunction

  assign accept = (state_q == IDLE) &
                  (bus.MemRead | bus.MemWrite);

  assign bus.Mem_Req_Ack     = (state_q == IDLE) & ~rst;
  assign bus.Read_data_Valid = (state_q == RESP);
  assign bus.Read_data       = rdata_q;

  always_comb begin
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8]
                                   : old_q[8*i +: 8];
  end

  assign Waddr = addr_q;
  assign Raddr = addr_q;
  assign Wren  = (state_q == WR);
  assign Rden  = (state_q == RD);
  assign Wdata = (state_q == WR) ? merged : 32'h0;

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: wait states, then read and/or write, then response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = LAT;
          if (LAT == 4'd0)
            state_d = route(bus.MemWrite, bus.Write_strb);
          else
            state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = route(is_wr_q, strb_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD:   state_d = is_wr_q ? WR : RESP;
      WR:   state_d = RESP;
      RESP: if (bus.Read_data_Ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      is_wr_q <= 1'b0;
      old_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else if (accept) begin
      addr_q  <= bus.Address[ADDR_WIDTH-1:2];
      wdata_q <= bus.Write_data;
      strb_q  <= bus.Write_strb;
      is_wr_q <= bus.MemWrite;
      rdata_q <= 32'h0;
    end else if (state_q == RD) begin
      if (is_wr_q) old_q   <= Rdata;
      else         rdata_q <= Rdata;
    end
  end

endmodule

// File: doc/mem_rmw_ctrl.md
MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14: byte-address width of the attached ideal memory; word address = ADDR_WIDTH-2 bits.
REQ-002 SHALL have parameter LATENCY, default 2, range 0..15: wait cycles inserted before each memory access.
REQ-003 SHALL have one clock and reset as follows. Reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 Address  in  32  CPU byte address; bits [1:0] and bits above ADDR_WIDTH-1 ignored.
REQ-007 MemWrite  in  1  write request.
REQ-008 MemRead  in  1  read request.
REQ-009 Write_data  in  32  store data, byte-lane aligned.
REQ-010 Write_strb  in  4  byte-lane enables; bit i covers Write_data[8i+7:8i].
REQ-011 Mem_Req_Ack  out  1  request accepted on edges where (MemRead|MemWrite) & Mem_Req_Ack.
REQ-012 Read_data  out  32  registered read result.
REQ-013 Read_data_Valid  out  1  response valid; held until Read_data_Ack.
REQ-014 Read_data_Ack  in  1  CPU consumes the response.
REQ-015 Waddr, Raddr  out  ADDR_WIDTH-2 each  memory write/read word addresses.
REQ-016 Wren, Rden  out  1 each  memory write enable / read enable.
REQ-017 Wdata  out  32  memory write data.
REQ-018 Rdata  in  32  memory read data; combinational from Raddr/Rden; memory writes on clk edge when Wren.

Function
REQ-019 States SHALL be IDLE, WAIT, RD, WR, RESP.
REQ-020 Mem_Req_Ack SHALL be 1 exactly when state is IDLE and rst is low.
REQ-021 On acceptance, SHALL latch word address Address[ADDR_WIDTH-1:2], Write_data, Write_strb and op type. MemWrite has priority when MemRead and MemWrite are both high.
REQ-022 After acceptance, SHALL go to WAIT when LATENCY>0 and stay there exactly LATENCY cycles. When LATENCY=0, WAIT SHALL be skipped.
REQ-023 After WAIT, routing SHALL be:
- read -> RD
- write with Write_strb=4'b1111 -> WR
- write with partial strobe -> RD then WR
- write with Write_strb=4'b0000 -> RESP directly; no memory access.
REQ-024 RD SHALL last 1 cycle with Rden=1 and Raddr=latched address. Rdata SHALL be captured at the closing edge into Read_data (read) or into an internal old-word register (partial write).
REQ-025 WR SHALL last 1 cycle with Wren=1, Waddr=latched address, and Wdata=byte-merge (strobed lanes from latched Write_data, other lanes from the old word).
REQ-026 Wren SHALL be 1 only in WR and Rden 1 only in RD. Waddr/Raddr SHALL be driven from the latched address in all states.
REQ-027 RESP SHALL assert Read_data_Valid and return to IDLE on the edge where Read_data_Ack=1.
REQ-028 For writes, Read_data SHALL be 32'h0 in RESP.
REQ-029 Read_data SHALL hold its value from capture until the next acceptance.
REQ-030 Latency from acceptance edge to the first edge with Read_data_Valid=1 SHALL be:
- read or full write: LATENCY+2 cycles
- partial write: LATENCY+3 cycles
- zero-strobe write: LATENCY+1 cycles.
REQ-031 Read_data_Ack outside RESP SHALL be ignored. Requests outside IDLE SHALL not be accepted and SHALL not alter latched state.
REQ-032 The latency counter SHALL be 4 bits and reload to LATENCY on each acceptance. It SHALL never wrap.

Reset
REQ-033 rst high SHALL immediately force: state IDLE, counter 0, Mem_Req_Ack=0, Read_data_Valid=0, Read_data=32'h0, Wren=0, Rden=0, Wdata=32'h0.
REQ-034 rst asserted mid-operation (including during WR) SHALL abort the operation with no memory write after the asserting edge. The first acceptance SHALL be possible on the first edge after rst deasserts.

Verification
REQ-035 Read: LATENCY=2, mem[4]=32'h241d0400, read Address=32'h10 -> Rden=1 for one cycle with Raddr=4; Read_data_Valid at acceptance+4 with Read_data=32'h241d0400.
REQ-036 Full write: Address=32'h228, Write_data=32'hdeadbeef, strb=4'hf -> one Wren cycle, Waddr=138, Wdata=32'hdeadbeef, no Rden; response at acceptance+4 with Read_data=0.
REQ-037 Partial write: mem[139]=32'h0000000c, Address=32'h22e, Write_data=32'h12340000, strb=4'b1100 -> RD then WR; Wdata=32'h1234000c; response at acceptance+5.
REQ-038 Backpressure/priority: MemRead=MemWrite=1 -> handled as write. Read_data_Ack held 0 for 5 cycles -> Read_data_Valid and Read_data stable; Mem_Req_Ack=0 throughout.
REQ-039 Reset in WR: assert rst during the WR cycle -> target word unchanged, all outputs at reset values; a read issued after release returns the old value.
REQ-040 LATENCY=0 and strb=0: LATENCY=0 read -> response at acceptance+2; write with strb=4'h0 -> no Wren/Rden pulse, response at acceptance+1.
